// File: rtl/count_leading_zeros_pkg.sv
//------------------------------------------------------------------------------
// count_leading_zeros_pkg
//   Shared sizing helper for the leading-zero counter and its users.
//   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package count_leading_zeros_pkg;

    // Width of a leading-zero count for a w-bit operand.
    function automatic int clz_width(input int w);
        return $clog2(w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/count_leading_zeros_clz_merge.sv
//------------------------------------------------------------------------------
// clz_merge
//   Combines the (valid, count) pairs of two adjacent halves into one node.
//   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clz_merge #(
    parameter int K = 1
) (
    input  logic         v_hi,
    input  logic [K-1:0] c_hi,
    input  logic         v_lo,
    input  logic [K-1:0] c_lo,
    output logic         v,
    output logic [K:0]   c
);

    assign v = v_hi | v_lo;
    // An empty upper half adds its full width to the lower half's count.
    assign c = v_hi ? {1'b0, c_hi} : {1'b1, c_lo};

endmodule

`default_nettype wire

// File: rtl/count_leading_zeros.sv
//------------------------------------------------------------------------------
// count_leading_zeros
//   Balanced-tree leading-zero counter with optional output register.
//   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module count_leading_zeros
    import count_leading_zeros_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int OUTPUT_REG = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             clz_input,
    output logic [clz_width(WIDTH)-1:0]  clz,
    output logic                         all_zero
);

    localparam int c_clz_w = clz_width(WIDTH);

    // Level j holds WIDTH>>(j+1) nodes, each with a (j+1)-bit count; levels
    // are packed back to back into flat buses so every bit is consumed.
    function automatic int v_off(input int j);
        int s;
        s = 0;
        for (int m = 0; m < j; m++) s += (WIDTH >> (m + 1));
        return s;
    endfunction

    function automatic int c_off(input int j);
        int s;
        s = 0;
        for (int m = 0; m < j; m++) s += (WIDTH >> (m + 1)) * (m + 1);
        return s;
    endfunction

    localparam int c_v_bits = v_off(c_clz_w);
    localparam int c_c_bits = c_off(c_clz_w);

    logic [c_v_bits-1:0] w_v;
    logic [c_c_bits-1:0] w_c;
    logic [c_clz_w-1:0]  w_clz;
    logic                w_all_zero;

    generate
        for (genvar i = 0; i < WIDTH / 2; i++) begin : g_leaf
            assign w_v[i] = clz_input[2*i+1] | clz_input[2*i];
            assign w_c[i] = ~clz_input[2*i+1];
        end

        for (genvar j = 1; j < c_clz_w; j++) begin : g_level
            for (genvar i = 0; i < (WIDTH >> (j + 1)); i++) begin : g_node
                localparam int c_pv = v_off(j - 1);
                localparam int c_pc = c_off(j - 1);
                localparam int c_sv = v_off(j);
                localparam int c_sc = c_off(j);

                clz_merge #(
                    .K (j)
                ) u_merge (
                    .v_hi (w_v[c_pv + 2*i + 1]),
                    .c_hi (w_c[c_pc + (2*i + 1)*j +: j]),
                    .v_lo (w_v[c_pv + 2*i]),
                    .c_lo (w_c[c_pc + (2*i)*j +: j]),
                    .v    (w_v[c_sv + i]),
                    .c    (w_c[c_sc + i*(j + 1) +: j + 1])
                );
            end
        end
    endgenerate

    assign w_clz      = w_c[c_c_bits-1 -: c_clz_w];
    assign w_all_zero = ~w_v[c_v_bits-1];

    generate
        if (OUTPUT_REG != 0) begin : g_reg
            logic [c_clz_w-1:0] r_clz;
            logic               r_all_zero;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_clz      <= '0;
                    r_all_zero <= 1'b0;
                end else begin
                    r_clz      <= w_clz;
                    r_all_zero <= w_all_zero;
                end
            end

            assign clz      = r_clz;
            assign all_zero = r_all_zero;
        end else begin : g_comb
            // Clock and reset have no load in the combinational build.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk | rst;

            assign clz      = w_clz;
            assign all_zero = w_all_zero;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_count_leading_zeros.sv
//------------------------------------------------------------------------------
// tb_count_leading_zeros
//   Directed and random checks of combinational and registered builds.
//   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_count_leading_zeros;

    logic        clk;
    logic        rst;
    logic [31:0] in32;
    logic [7:0]  in8;
    logic [63:0] in64;
    logic [31:0] in_r;

    logic [4:0]  clz32;
    logic        az32;
    logic [2:0]  clz8;
    logic        az8;
    logic [5:0]  clz64;
    logic        az64;
    logic [4:0]  clz_r;
    logic        az_r;

    int nchecks = 0;
    int nerrors = 0;

    count_leading_zeros #(.WIDTH(32), .OUTPUT_REG(0)) u_dut32 (
        .clk(clk), .rst(rst), .clz_input(in32), .clz(clz32), .all_zero(az32));
    count_leading_zeros #(.WIDTH(8), .OUTPUT_REG(0)) u_dut8 (
        .clk(clk), .rst(rst), .clz_input(in8), .clz(clz8), .all_zero(az8));
    count_leading_zeros #(.WIDTH(64), .OUTPUT_REG(0)) u_dut64 (
        .clk(clk), .rst(rst), .clz_input(in64), .clz(clz64), .all_zero(az64));
    count_leading_zeros #(.WIDTH(32), .OUTPUT_REG(1)) u_dut_r (
        .clk(clk), .rst(rst), .clz_input(in_r), .clz(clz_r), .all_zero(az_r));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: scan down from the MSB.
    function automatic int ref_clz(input logic [63:0] x, input int w);
        for (int b = w - 1; b >= 0; b--)
            if (x[b]) return w - 1 - b;
        return w - 1;
    endfunction

    initial begin
        logic [63:0] x;
        logic [63:0] mask;

        rst  = 1'b1;
        in32 = '0;
        in8  = '0;
        in64 = '0;
        in_r = 32'h0000_0001;

        // Directed 32-bit vectors
        in32 = 32'h8000_0000; #1;
        check("msb_clz", 64'(clz32), 64'd0);
        check("msb_az", 64'(az32), 64'd0);
        in32 = 32'h4000_0000; #1;
        check("bit30_clz", 64'(clz32), 64'd1);
        in32 = 32'h0000_0001; #1;
        check("one_clz", 64'(clz32), 64'd31);
        check("one_az", 64'(az32), 64'd0);
        check("one_zdet", 64'((&clz32) & ~in32[0]), 64'd0);
        in32 = 32'h0000_0000; #1;
        check("zero_clz", 64'(clz32), 64'd31);
        check("zero_az", 64'(az32), 64'd1);
        check("zero_zdet", 64'((&clz32) & ~in32[0]), 64'd1);
        in32 = 32'h0001_0000; #1;
        check("bit16_clz", 64'(clz32), 64'd15);
        in32 = 32'h0000_FFFF; #1;
        check("lowhalf_clz", 64'(clz32), 64'd16);
        in32 = 32'hFFFF_FFFF; #1;
        check("ones_clz", 64'(clz32), 64'd0);
        check("ones_az", 64'(az32), 64'd0);

        // Directed 8- and 64-bit corners
        in8 = 8'h00; #1;
        check("w8_zero_clz", 64'(clz8), 64'd7);
        check("w8_zero_az", 64'(az8), 64'd1);
        in8 = 8'h10; #1;
        check("w8_bit4_clz", 64'(clz8), 64'd3);
        in64 = 64'h0000_0001_0000_0000; #1;
        check("w64_bit32_clz", 64'(clz64), 64'd31);
        in64 = 64'h0; #1;
        check("w64_zero_clz", 64'(clz64), 64'd63);
        check("w64_zero_az", 64'(az64), 64'd1);

        // Walking one with random lower bits
        for (int i = 0; i < 32; i++) begin
            mask = (64'd1 << i) - 64'd1;
            x = (64'd1 << i) | ({$urandom, $urandom} & mask);
            in32 = x[31:0]; #1;
            check("walk32", 64'(clz32), 64'(31 - i));
        end
        for (int i = 0; i < 8; i++) begin
            mask = (64'd1 << i) - 64'd1;
            x = (64'd1 << i) | ({$urandom, $urandom} & mask);
            in8 = x[7:0]; #1;
            check("walk8", 64'(clz8), 64'(7 - i));
        end
        for (int i = 0; i < 64; i++) begin
            mask = (i == 0) ? 64'd0 : ((64'd1 << i) - 64'd1);
            x = (64'd1 << i) | ({$urandom, $urandom} & mask);
            in64 = x; #1;
            check("walk64", 64'(clz64), 64'(63 - i));
        end

        // Random operands; shift right randomly so small values appear too
        for (int n = 0; n < 10000; n++) begin
            x = {$urandom, $urandom} >> $urandom_range(63, 0);
            in32 = x[31:0];
            in8  = x[7:0];
            in64 = x;
            #1;
            check("rand32", 64'(clz32), 64'(ref_clz(x, 32)));
            check("rand32_az", 64'(az32), 64'(x[31:0] == 32'd0));
            check("rand8", 64'(clz8), 64'(ref_clz(x, 8)));
            check("rand8_az", 64'(az8), 64'(x[7:0] == 8'd0));
            check("rand64", 64'(clz64), 64'(ref_clz(x, 64)));
            check("rand64_az", 64'(az64), 64'(x == 64'd0));
        end

        // Registered build: reset holds outputs at "MSB set" despite input 1
        @(negedge clk);
        rst  = 1'b1;
        in_r = 32'h0000_0001;
        repeat (2) @(posedge clk);
        #1;
        check("reg_rst_clz", 64'(clz_r), 64'd0);
        check("reg_rst_az", 64'(az_r), 64'd0);

        @(negedge clk);
        rst  = 1'b0;
        in_r = 32'h0000_0100;
        @(posedge clk);
        #1;
        check("reg_100_clz", 64'(clz_r), 64'd23);
        check("reg_100_az", 64'(az_r), 64'd0);
        in_r = 32'h0000_0000;
        @(posedge clk);
        #1;
        check("reg_zero_clz", 64'(clz_r), 64'd31);
        check("reg_zero_az", 64'(az_r), 64'd1);

        // Reset wins over a valid operand on the same edge
        @(negedge clk);
        rst  = 1'b1;
        in_r = 32'h0000_0000;
        @(posedge clk);
        #1;
        check("reg_rstpri_clz", 64'(clz_r), 64'd0);
        check("reg_rstpri_az", 64'(az_r), 64'd0);

        @(negedge clk);
        rst  = 1'b0;
        in_r = 32'h0000_0008;
        @(posedge clk);
        #1;
        check("reg_after_clz", 64'(clz_r), 64'd28);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

`default_nettype wire
